vm: RTL and testbench

VM -- requirements
Module: vm

---
 rtl/vm.sv | 99 +++++++++
 tb/tb_vm.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/vm.sv
// Coin-operated vending controller: credit held as states S0..S30 (Rs5 steps),
// one-cycle registered dispense pulses with change/refund on the same cycle.
module vm (
    input  logic       clk,
    input  logic       reset,
    input  logic       cancel,
    input  logic [1:0] sel,
    input  logic [1:0] coin,
    output logic       pa,
    output logic       pb,
    output logic       pc,
    output logic [4:0] change,
    output logic [2:0] o_state
);

    typedef enum logic [2:0] {
        S0  = 3'd0,
        S5  = 3'd1,
        S10 = 3'd2,
        S15 = 3'd3,
        S20 = 3'd4,
        S25 = 3'd5,
        S30 = 3'd6
    } state_t;

    state_t     r_state;
    logic       r_pa;
    logic       r_pb;
    logic       r_pc;
    logic [4:0] r_change;

    logic [4:0] w_credit;
    logic       w_coin_valid;
    logic [2:0] w_coin_steps;
    logic [4:0] w_coin_val;
    logic [3:0] w_sum_steps;
    logic       w_sel_valid;
    logic [4:0] w_price;
    logic       w_afford;

    // State encoding is the credit in Rs5 units, so credit = state * 5.
    assign w_credit     = {r_state, 2'b00} + {2'b00, r_state};
    assign w_coin_valid = (coin == 2'b01) || (coin == 2'b10);
    assign w_coin_steps = {1'b0, coin};
    assign w_coin_val   = {w_coin_steps, 2'b00} + {2'b00, w_coin_steps};
    assign w_sum_steps  = {1'b0, r_state} + {1'b0, w_coin_steps};

    always_comb begin
        w_sel_valid = 1'b1;
        w_price     = 5'd0;
        case (sel)
            2'b00:   w_price = 5'd5;
            2'b01:   w_price = 5'd10;
            2'b10:   w_price = 5'd20;
            default: w_sel_valid = 1'b0;
        endcase
    end

    assign w_afford = w_sel_valid && (w_price <= w_credit);

    // Priority per edge: reset, cancel, coin, selection.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S0;
            r_pa     <= 1'b0;
            r_pb     <= 1'b0;
            r_pc     <= 1'b0;
            r_change <= 5'd0;
        end else begin
            r_pa     <= 1'b0;
            r_pb     <= 1'b0;
            r_pc     <= 1'b0;
            r_change <= 5'd0;
            if (cancel) begin
                r_change <= w_credit;
                r_state  <= S0;
            end else if (w_coin_valid) begin
                if (w_sum_steps > 4'd6) begin
                    r_change <= w_coin_val;
                end else begin
                    r_state <= state_t'(w_sum_steps[2:0]);
                end
            end else if (w_afford) begin
                r_pa     <= (sel == 2'b00);
                r_pb     <= (sel == 2'b01);
                r_pc     <= (sel == 2'b10);
                r_change <= w_credit - w_price;
                r_state  <= S0;
            end
        end
    end

    assign pa      = r_pa;
    assign pb      = r_pb;
    assign pc      = r_pc;
    assign change  = r_change;
    assign o_state = r_state;

endmodule

// File: tb/tb_vm.sv
// Directed vector bench for the vending controller: table of per-cycle
// inputs with expected pulses, change and credit state, plus hand sequences.
module tb_vm;

    logic       clk;
    logic       reset;
    logic       cancel;
    logic [1:0] sel;
    logic [1:0] coin;
    logic       pa;
    logic       pb;
    logic       pc;
    logic [4:0] change;
    logic [2:0] o_state;

    vm dut (
        .clk     (clk),
        .reset   (reset),
        .cancel  (cancel),
        .sel     (sel),
        .coin    (coin),
        .pa      (pa),
        .pb      (pb),
        .pc      (pc),
        .change  (change),
        .o_state (o_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       can;
        logic [1:0] sel;
        logic [1:0] coin;
        logic       pa;
        logic       pb;
        logic       pc;
        logic [4:0] chg;
        logic [2:0] st;
    } vec_t;

    vec_t vecs[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic add(input logic r, input logic c, input logic [1:0] s, input logic [1:0] k,
                       input logic ea, input logic eb, input logic ec,
                       input logic [4:0] ech, input logic [2:0] est);
        vec_t v;
        v.rst = r; v.can = c; v.sel = s; v.coin = k;
        v.pa = ea; v.pb = eb; v.pc = ec; v.chg = ech; v.st = est;
        vecs.push_back(v);
    endtask

    // Drive one cycle of inputs on the falling edge, check #1 after the rising edge.
    task automatic step(input string name, input logic r, input logic c,
                        input logic [1:0] s, input logic [1:0] k,
                        input logic ea, input logic eb, input logic ec,
                        input logic [4:0] ech, input logic [2:0] est);
        @(negedge clk);
        reset = r; cancel = c; sel = s; coin = k;
        @(posedge clk);
        #1;
        n_total++;
        if (pa === ea && pb === eb && pc === ec && change === ech && o_state === est) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got pa=%b pb=%b pc=%b change=%0d state=%0d, want pa=%b pb=%b pc=%b change=%0d state=%0d",
                     name, pa, pb, pc, change, o_state, ea, eb, ec, ech, est);
        end
    endtask

    initial begin
        reset = 1'b1; cancel = 1'b0; sel = 2'b11; coin = 2'b00;

        // reset
        add(1, 0, 2'b11, 2'b00, 0, 0, 0, 5'd0, 3'd0);
        // Rs5 then A: exact
        add(0, 0, 2'b11, 2'b01, 0, 0, 0, 5'd0, 3'd1);
        add(0, 0, 2'b00, 2'b00, 1, 0, 0, 5'd0, 3'd0);
        // Rs10 then A: change 5; Rs10 then B: exact
        add(0, 0, 2'b11, 2'b10, 0, 0, 0, 5'd0, 3'd2);
        add(0, 0, 2'b00, 2'b00, 1, 0, 0, 5'd5, 3'd0);
        add(0, 0, 2'b11, 2'b10, 0, 0, 0, 5'd0, 3'd2);
        add(0, 0, 2'b01, 2'b00, 0, 1, 0, 5'd0, 3'd0);
        // Rs15 then B: change 5
        add(0, 0, 2'b11, 2'b10, 0, 0, 0, 5'd0, 3'd2);
        add(0, 0, 2'b11, 2'b01, 0, 0, 0, 5'd0, 3'd3);
        add(0, 0, 2'b01, 2'b00, 0, 1, 0, 5'd5, 3'd0);
        // Rs20 then C: exact
        add(0, 0, 2'b11, 2'b10, 0, 0, 0, 5'd0, 3'd2);
        add(0, 0, 2'b11, 2'b10, 0, 0, 0, 5'd0, 3'd4);
        add(0, 0, 2'b10, 2'b00, 0, 0, 1, 5'd0, 3'd0);
        // Rs15 cancel (coin and sel ignored), Rs5 cancel, cancel at S0
        add(0, 0, 2'b11, 2'b10, 0, 0, 0, 5'd0, 3'd2);
        add(0, 0, 2'b11, 2'b01, 0, 0, 0, 5'd0, 3'd3);
        add(0, 1, 2'b00, 2'b10, 0, 0, 0, 5'd15, 3'd0);
        add(0, 0, 2'b11, 2'b01, 0, 0, 0, 5'd0, 3'd1);
        add(0, 1, 2'b11, 2'b00, 0, 0, 0, 5'd5, 3'd0);
        add(0, 1, 2'b11, 2'b00, 0, 0, 0, 5'd0, 3'd0);
        // Rs10 select C: insufficient, credit kept; then +10 and C
        add(0, 0, 2'b11, 2'b10, 0, 0, 0, 5'd0, 3'd2);
        add(0, 0, 2'b10, 2'b00, 0, 0, 0, 5'd0, 3'd2);
        add(0, 0, 2'b11, 2'b10, 0, 0, 0, 5'd0, 3'd4);
        add(0, 0, 2'b10, 2'b00, 0, 0, 1, 5'd0, 3'd0);
        // Fill to Rs30; overflow coins returned, sel ignored when a coin arrives
        add(0, 0, 2'b11, 2'b10, 0, 0, 0, 5'd0, 3'd2);
        add(0, 0, 2'b11, 2'b10, 0, 0, 0, 5'd0, 3'd4);
        add(0, 0, 2'b11, 2'b10, 0, 0, 0, 5'd0, 3'd6);
        add(0, 0, 2'b11, 2'b01, 0, 0, 0, 5'd5, 3'd6);
        add(0, 0, 2'b00, 2'b10, 0, 0, 0, 5'd10, 3'd6);
        add(0, 0, 2'b11, 2'b00, 0, 0, 0, 5'd0, 3'd6);
        add(0, 0, 2'b10, 2'b00, 0, 0, 1, 5'd10, 3'd0);
        // Rs25 + Rs5 reaches exactly Rs30 (boundary accepted)
        add(0, 0, 2'b11, 2'b10, 0, 0, 0, 5'd0, 3'd2);
        add(0, 0, 2'b11, 2'b10, 0, 0, 0, 5'd0, 3'd4);
        add(0, 0, 2'b11, 2'b01, 0, 0, 0, 5'd0, 3'd5);
        add(0, 0, 2'b11, 2'b01, 0, 0, 0, 5'd0, 3'd6);
        add(0, 1, 2'b11, 2'b00, 0, 0, 0, 5'd30, 3'd0);
        // Reset at Rs15 discards credit, overriding cancel and coin
        add(0, 0, 2'b11, 2'b10, 0, 0, 0, 5'd0, 3'd2);
        add(0, 0, 2'b11, 2'b01, 0, 0, 0, 5'd0, 3'd3);
        add(1, 1, 2'b00, 2'b10, 0, 0, 0, 5'd0, 3'd0);
        // Invalid coin 11 is ignored, so selection acts
        add(0, 0, 2'b11, 2'b01, 0, 0, 0, 5'd0, 3'd1);
        add(0, 0, 2'b11, 2'b11, 0, 0, 0, 5'd0, 3'd1);
        add(0, 0, 2'b00, 2'b11, 1, 0, 0, 5'd0, 3'd0);
        // Coin with sel=00 at S0: coin wins, then B
        add(0, 0, 2'b00, 2'b10, 0, 0, 0, 5'd0, 3'd2);
        add(0, 0, 2'b01, 2'b00, 0, 1, 0, 5'd0, 3'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            step($sformatf("vec%0d", i), vecs[i].rst, vecs[i].can, vecs[i].sel, vecs[i].coin,
                 vecs[i].pa, vecs[i].pb, vecs[i].pc, vecs[i].chg, vecs[i].st);
        end

        // Hold Rs30 across several idle cycles, then A returns Rs25 and the pulse drops.
        step("hold_fill1", 0, 0, 2'b11, 2'b10, 0, 0, 0, 5'd0, 3'd2);
        step("hold_fill2", 0, 0, 2'b11, 2'b10, 0, 0, 0, 5'd0, 3'd4);
        step("hold_fill3", 0, 0, 2'b11, 2'b10, 0, 0, 0, 5'd0, 3'd6);
        for (int i = 0; i < 5; i++) begin
            step($sformatf("hold_idle%0d", i), 0, 0, 2'b11, 2'b00, 0, 0, 0, 5'd0, 3'd6);
        end
        step("hold_buy_a", 0, 0, 2'b00, 2'b00, 1, 0, 0, 5'd25, 3'd0);
        step("pulse_drop", 0, 0, 2'b11, 2'b00, 0, 0, 0, 5'd0, 3'd0);
        // Selection with no credit dispenses nothing.
        step("no_credit_a", 0, 0, 2'b00, 2'b00, 0, 0, 0, 5'd0, 3'd0);
        step("no_credit_c", 0, 0, 2'b10, 2'b00, 0, 0, 0, 5'd0, 3'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    always @(negedge clk) begin
        if ((pa + pb + pc) > 1) begin
            $display("FAIL onehot: pa=%b pb=%b pc=%b, want at most one high", pa, pb, pc);
        end
    end

endmodule
